// File: rtl/pkt_pkg.sv
// ----------------------------------------------------------------------------
// pkt_pkg
// Shared definitions for the ingress packet CRC-8 checker. The transmit-side
// appender uses the same CRC constants and byte-step function.
//   CRC8_POLY / CRC8_INIT : CRC-8 polynomial and seed value
//   state_t               : checker FSM states
//   crc8_byte()           : advance a CRC-8 value by one byte, LSB first
// ----------------------------------------------------------------------------
package pkt_pkg;

   localparam logic [7:0] CRC8_POLY = 8'hAB;
   localparam logic [7:0] CRC8_INIT = 8'hE7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      DROP = 2'd2
   } state_t;

   // Shift register form: the data bit enters at the LSB and the bit that
   // falls out of the MSB decides whether the polynomial is folded in.
   // There is no final XOR.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                            input logic [7:0] data);
      logic [7:0] c;
      logic       msb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         msb = c[7];
         c   = {c[6:0], data[i]};
         if (msb) c = c ^ CRC8_POLY;
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_step.sv
// ----------------------------------------------------------------------------
// crc8_step
// Combinational one-byte CRC-8 update (poly 8'hAB, bits taken LSB first).
// Ports:
//   crc_in  [7:0]  current CRC value
//   data    [7:0]  byte to absorb
//   crc_out [7:0]  CRC value after absorbing data
// ----------------------------------------------------------------------------
module crc8_step
   import pkt_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   assign crc_out = crc8_byte(crc_in, data);

endmodule

// File: rtl/pkt_crc_check.sv
// ----------------------------------------------------------------------------
// pkt_crc_check
// Receive-side CRC-8 checker. Accepts framed packets whose last byte is the
// CRC-8 of all preceding bytes, forwards the payload with the CRC byte
// stripped, flags bad packets on the final payload byte and keeps saturating
// good/bad packet counters.
//
// Stream protocol: both sides are valid-only streams with no backpressure.
// A beat is transferred on every rising clk edge where *_valid is 1; *_sop,
// *_eop and *_data are meaningful only on such beats. out_err is meaningful
// only on a beat with out_eop = 1. in_valid may drop low at any point.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid        input byte strobe
//   in_data [7:0]   input byte
//   in_sop, in_eop  first byte / last (CRC) byte of packet
//   out_valid       payload byte strobe (one-cycle pulse per byte)
//   out_data [7:0]  payload byte
//   out_sop/out_eop first / last payload byte
//   out_err         packet bad (with out_eop)
//   pkt_ok_cnt      saturating count of good packets
//   pkt_err_cnt     saturating count of bad packets
//   dbg_state       current FSM state, for observation only
// ----------------------------------------------------------------------------
module pkt_crc_check
   import pkt_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int CNT_W   = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_sop,
   input  logic             in_eop,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_sop,
   output logic             out_eop,
   output logic             out_err,
   output logic [CNT_W-1:0] pkt_ok_cnt,
   output logic [CNT_W-1:0] pkt_err_cnt,
   output state_t           dbg_state
);

   localparam int               LEN_W     = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W:0]   MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q;
   state_t           state_d;

   // Datapath registers
   logic [7:0]       crc_q;
   logic [LEN_W-1:0] len_q;        // bytes accepted so far in this packet
   logic [7:0]       hold_data;    // most recent byte, not yet known to be payload
   logic             hold_sop;

   // Control decode
   logic             emit;         // push the held byte to out_*
   logic             emit_eop;
   logic             emit_err;
   logic             load;         // capture in_data into the hold register
   logic             seed;         // restart CRC and length from a sop byte
   logic             ok_inc;
   logic [1:0]       err_amt;      // a missing eop plus a runt sop counts twice

   logic [7:0]       crc_base;
   logic [7:0]       crc_next;
   logic [LEN_W:0]   len_inc;
   logic             len_ovf;
   logic             crc_bad;
   logic [CNT_W:0]   err_sum;

   crc8_step u_crc8_step (
      .crc_in  (crc_base),
      .data    (in_data),
      .crc_out (crc_next)
   );

   assign crc_base  = seed ? CRC8_INIT : crc_q;
   assign crc_bad   = (in_data != crc_q);
   assign len_inc   = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
   // A non-final byte landing at position MAX_LEN means the CRC byte can only
   // arrive beyond MAX_LEN, so the packet is already known to be too long.
   // A final byte in BODY always fits, because len_q never exceeds MAX_LEN-1.
   assign len_ovf   = (len_inc >= MAX_LEN_V);
   assign err_sum   = {1'b0, pkt_err_cnt} + (CNT_W + 1)'(err_amt);
   assign dbg_state = state_q;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_sop && !in_eop) state_d = BODY;
         end
         BODY: begin
            if (in_valid) begin
               if (in_sop)       state_d = in_eop ? IDLE : BODY;
               else if (in_eop)  state_d = IDLE;
               else if (len_ovf) state_d = DROP;
               else              state_d = BODY;
            end
         end
         DROP: begin
            if (in_valid) begin
               if (in_sop)      state_d = in_eop ? IDLE : BODY;
               else if (in_eop) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------- output decode
   always_comb begin
      emit     = 1'b0;
      emit_eop = 1'b0;
      emit_err = 1'b0;
      load     = 1'b0;
      seed     = 1'b0;
      ok_inc   = 1'b0;
      err_amt  = 2'd0;
      case (state_q)
         IDLE, DROP: begin
            // DROP only reacts to a sop, which restarts exactly like IDLE.
            if (in_valid && in_sop) begin
               if (in_eop) begin
                  err_amt = 2'd1;                 // runt
               end else begin
                  load = 1'b1;
                  seed = 1'b1;
               end
            end
         end
         BODY: begin
            if (in_valid) begin
               if (in_sop) begin
                  // Previous packet lost its eop: close it as bad, then
                  // handle the new sop byte as a fresh start.
                  emit     = 1'b1;
                  emit_eop = 1'b1;
                  emit_err = 1'b1;
                  if (in_eop) begin
                     err_amt = 2'd2;
                  end else begin
                     err_amt = 2'd1;
                     load    = 1'b1;
                     seed    = 1'b1;
                  end
               end else if (in_eop) begin
                  emit     = 1'b1;
                  emit_eop = 1'b1;
                  emit_err = crc_bad;
                  ok_inc   = !crc_bad;
                  err_amt  = {1'b0, crc_bad};
               end else if (len_ovf) begin
                  emit     = 1'b1;
                  emit_eop = 1'b1;
                  emit_err = 1'b1;
                  err_amt  = 2'd1;
               end else begin
                  emit = 1'b1;
                  load = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_data    <= 8'h00;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_err     <= 1'b0;
         crc_q       <= CRC8_INIT;
         len_q       <= '0;
         hold_data   <= 8'h00;
         hold_sop    <= 1'b0;
         pkt_ok_cnt  <= '0;
         pkt_err_cnt <= '0;
      end else begin
         out_valid <= emit;
         out_sop   <= emit & hold_sop;
         out_eop   <= emit & emit_eop;
         out_err   <= emit & emit_err;
         if (emit) out_data <= hold_data;

         if (load) begin
            hold_data <= in_data;
            hold_sop  <= seed;
            crc_q     <= crc_next;
            len_q     <= seed ? LEN_W'(1) : len_inc[LEN_W-1:0];
         end

         if (ok_inc && (pkt_ok_cnt != CNT_MAX))
            pkt_ok_cnt <= pkt_ok_cnt + 1'b1;

         if (err_sum[CNT_W]) pkt_err_cnt <= CNT_MAX;
         else                pkt_err_cnt <= err_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_pkt_crc_check.sv
// ----------------------------------------------------------------------------
// tb_pkt_crc_check
// Drives byte streams into two checker instances (16-bit and 2-bit counters,
// both MAX_LEN = 4). A packet-level reference model keeps the bytes of the
// current packet in a queue and predicts every output cycle; one compare
// process checks each cycle against the expected queue.
// ----------------------------------------------------------------------------
module tb_pkt_crc_check;

   localparam int MAX_LEN = 4;
   localparam int CNT_W   = 16;
   localparam int SAT_W   = 2;

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_sop;
   logic             in_eop;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_sop;
   logic             out_eop;
   logic             out_err;
   logic [CNT_W-1:0] pkt_ok_cnt;
   logic [CNT_W-1:0] pkt_err_cnt;
   logic [1:0]       dbg_state;

   logic             s_out_valid;
   logic [7:0]       s_out_data;
   logic             s_out_sop;
   logic             s_out_eop;
   logic             s_out_err;
   logic [SAT_W-1:0] s_ok_cnt;
   logic [SAT_W-1:0] s_err_cnt;
   logic [1:0]       s_dbg_state;

   pkt_crc_check #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_err    (out_err),
      .pkt_ok_cnt (pkt_ok_cnt),
      .pkt_err_cnt(pkt_err_cnt),
      .dbg_state  (dbg_state)
   );

   pkt_crc_check #(.MAX_LEN(MAX_LEN), .CNT_W(SAT_W)) dut_sat (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .out_valid  (s_out_valid),
      .out_data   (s_out_data),
      .out_sop    (s_out_sop),
      .out_eop    (s_out_eop),
      .out_err    (s_out_err),
      .pkt_ok_cnt (s_ok_cnt),
      .pkt_err_cnt(s_err_cnt),
      .dbg_state  (s_dbg_state)
   );

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      bit         valid;
      logic [7:0] data;
      bit         sop;
      bit         eop;
      bit         err;
      int         ok;
      int         bad;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // -------------------------------------------------------- reference model
   function automatic logic [7:0] crc8_byte(input logic [7:0] c_in,
                                            input logic [7:0] d);
      logic [7:0] c;
      logic       msb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         msb = c[7];
         c   = {c[6:0], d[i]};
         if (msb) c = c ^ 8'hAB;
      end
      return c;
   endfunction

   bit         m_in_pkt = 1'b0;
   bit         m_drop   = 1'b0;
   logic [7:0] m_pkt[$];
   int         m_ok  = 0;
   int         m_bad = 0;

   function automatic logic [7:0] crc_of_pkt();
      logic [7:0] c;
      c = 8'hE7;
      foreach (m_pkt[i]) c = crc8_byte(c, m_pkt[i]);
      return c;
   endfunction

   // The last byte seen so far becomes a payload byte once a later byte arrives.
   task automatic emit_last(inout exp_t x, input bit eop, input bit err);
      x.valid = 1'b1;
      x.data  = m_pkt[m_pkt.size() - 1];
      x.sop   = (m_pkt.size() == 1);
      x.eop   = eop;
      x.err   = err;
   endtask

   task automatic start_pkt(input logic [7:0] d, input bit s, input bit e);
      if (s && !e) begin
         m_pkt.delete();
         m_pkt.push_back(d);
         m_in_pkt = 1'b1;
      end else if (s && e) begin
         m_bad++;
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] d,
                             input bit s, input bit e);
      exp_t x;
      bit   bad_crc;
      x = '{valid: 1'b0, data: 8'h00, sop: 1'b0, eop: 1'b0, err: 1'b0, ok: 0, bad: 0};
      if (r) begin
         m_in_pkt = 1'b0;
         m_drop   = 1'b0;
         m_pkt.delete();
         m_ok     = 0;
         m_bad    = 0;
      end else if (v) begin
         if (m_in_pkt) begin
            if (s) begin
               emit_last(x, 1'b1, 1'b1);
               m_bad++;
               m_in_pkt = 1'b0;
               start_pkt(d, s, e);
            end else if (e) begin
               bad_crc = (d != crc_of_pkt());
               emit_last(x, 1'b1, bad_crc);
               if (bad_crc) m_bad++;
               else         m_ok++;
               m_in_pkt = 1'b0;
            end else if (m_pkt.size() + 1 >= MAX_LEN) begin
               // Another non-CRC byte here means the packet exceeds MAX_LEN.
               emit_last(x, 1'b1, 1'b1);
               m_bad++;
               m_in_pkt = 1'b0;
               m_drop   = 1'b1;
            end else begin
               emit_last(x, 1'b0, 1'b0);
               m_pkt.push_back(d);
            end
         end else if (m_drop) begin
            if (s) begin
               m_drop = 1'b0;
               start_pkt(d, s, e);
            end else if (e) begin
               m_drop = 1'b0;
            end
         end else begin
            start_pkt(d, s, e);
         end
      end
      x.ok  = m_ok;
      x.bad = m_bad;
      exp_q.push_back(x);
   endtask

   // ------------------------------------------------------- compare process
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL exp_queue: got empty queue, expected an entry (t=%0t)", $time);
      end else begin
         e = exp_q.pop_front();
         check("out_valid", 32'(out_valid), 32'(e.valid));
         if (e.valid) begin
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sop",  32'(out_sop),  32'(e.sop));
            check("out_eop",  32'(out_eop),  32'(e.eop));
            if (e.eop) check("out_err", 32'(out_err), 32'(e.err));
         end
         check("pkt_ok_cnt",  32'(pkt_ok_cnt),  32'(sat(e.ok,  CNT_W)));
         check("pkt_err_cnt", 32'(pkt_err_cnt), 32'(sat(e.bad, CNT_W)));
         check("sat_ok_cnt",  32'(s_ok_cnt),    32'(sat(e.ok,  SAT_W)));
         check("sat_err_cnt", 32'(s_err_cnt),   32'(sat(e.bad, SAT_W)));
      end
   end

   // -------------------------------------------------------- driver tasks
   task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                      input bit s, input bit e);
      @(negedge clk);
      reset    = r;
      in_valid = v;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      model_step(r, v, d, s, e);
   endtask

   task automatic send(input logic [7:0] d, input bit s, input bit e);
      cyc(1'b0, 1'b1, d, s, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // -------------------------------------------------------------- stimulus
   logic [7:0] pl[8];

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      model_step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Pin the model CRC against hand-computed values.
      check("pin_crc_00",   32'(crc8_byte(8'hE7, 8'h00)), 32'h0E7);
      check("pin_crc_01",   32'(crc8_byte(8'hE7, 8'h01)), 32'h067);
      check("pin_crc_0000", 32'(crc8_byte(crc8_byte(8'hE7, 8'h00), 8'h00)), 32'h0E7);

      do_reset();
      idle(1);
      check("lit_reset_ok",  32'(pkt_ok_cnt),  32'd0);
      check("lit_reset_err", 32'(pkt_err_cnt), 32'd0);
      check("lit_reset_val", 32'(out_valid),   32'd0);

      // Good packets
      send(8'h00, 1, 0); send(8'hE7, 0, 1);
      send(8'h01, 1, 0); send(8'h67, 0, 1);
      send(8'h00, 1, 0); send(8'h00, 0, 0); send(8'hE7, 0, 1);
      idle(1);
      check("lit_good_ok",  32'(pkt_ok_cnt),  32'd3);
      check("lit_good_err", 32'(pkt_err_cnt), 32'd0);

      // Bad CRC with gaps
      send(8'h01, 1, 0); idle(2); send(8'h68, 0, 1);
      idle(1);
      check("lit_badcrc_err", 32'(pkt_err_cnt), 32'd1);

      // Stray bytes and a runt
      send(8'h55, 0, 0); send(8'hAA, 0, 0);
      send(8'h12, 1, 1);
      idle(1);
      check("lit_runt_err", 32'(pkt_err_cnt), 32'd2);
      check("lit_runt_ok",  32'(pkt_ok_cnt),  32'd3);

      // Overlength: sop + 5 bytes + eop, then a clean packet
      send(8'h10, 1, 0);
      for (int i = 1; i <= 5; i++) send(8'(8'h10 + i), 0, 0);
      send(8'h16, 0, 1);
      send(8'h00, 1, 0); send(8'hE7, 0, 1);
      idle(1);
      check("lit_ovf_err", 32'(pkt_err_cnt), 32'd3);
      check("lit_ovf_ok",  32'(pkt_ok_cnt),  32'd4);

      // Missing eop
      send(8'h00, 1, 0); send(8'h11, 0, 0);
      send(8'h01, 1, 0); send(8'h67, 0, 1);
      idle(1);
      check("lit_noeop_err", 32'(pkt_err_cnt), 32'd4);
      check("lit_noeop_ok",  32'(pkt_ok_cnt),  32'd5);
      check("lit_sat_ok",    32'(s_ok_cnt),    32'd3);
      check("lit_sat_err",   32'(s_err_cnt),   32'd3);

      // Reset mid-packet
      send(8'h20, 1, 0); send(8'h21, 0, 0);
      do_reset();
      idle(1);
      check("lit_midrst_val", 32'(out_valid),   32'd0);
      check("lit_midrst_ok",  32'(pkt_ok_cnt),  32'd0);
      check("lit_midrst_err", 32'(pkt_err_cnt), 32'd0);
      send(8'h22, 0, 1);
      idle(2);

      // Randomized traffic
      for (int p = 0; p < 400; p++) begin
         int         k;
         int         len;
         bit         good;
         bit         no_eop;
         logic [7:0] c;
         k = $urandom_range(0, 19);
         if (k == 0) begin
            do_reset();
         end else if (k == 1) begin
            send(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
         end else begin
            len    = $urandom_range(1, 6);
            good   = ($urandom_range(0, 3) != 0);
            no_eop = ($urandom_range(0, 9) == 0);
            c      = 8'hE7;
            for (int i = 0; i < len - 1; i++) begin
               pl[i] = 8'($urandom_range(0, 255));
               c     = crc8_byte(c, pl[i]);
            end
            if (!good) c = c ^ 8'($urandom_range(1, 255));
            for (int i = 0; i < len - 1; i++) begin
               send(pl[i], (i == 0), 1'b0);
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if (!no_eop) send(c, (len == 1), 1'b1);
         end
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(3);
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
